// File: rtl/line_buf_pkg.sv
// Shared definitions for the 4-line rotating line buffer (write and read sides).
package line_buf_pkg;

  localparam int NUM_LINE_BUFS    = 4;
  localparam int LINES_FOR_WINDOW = 3;

  // Index of one of the four line buffers; 2 bits so that +1 wraps naturally.
  typedef logic [1:0]               buf_idx_t;
  typedef logic [NUM_LINE_BUFS-1:0] buf_en_t;

  // Completed-line counter, saturating at LINES_FOR_WINDOW.
  typedef logic [1:0] line_cnt_t;
  localparam line_cnt_t LINE_CNT_FULL = line_cnt_t'(LINES_FOR_WINDOW);

  // FILL while fewer than LINES_FOR_WINDOW lines are stored, STREAM afterwards.
  typedef enum logic {
    PHASE_FILL   = 1'b0,
    PHASE_STREAM = 1'b1
  } phase_t;

  // Next buffer in the rotation; the read side uses the same function to find
  // the oldest stored line relative to the published select.
  function automatic buf_idx_t next_buf_idx(input buf_idx_t idx);
    return idx + buf_idx_t'(1);
  endfunction

  // One-hot write enable for buffer idx.
  function automatic buf_en_t buf_onehot(input buf_idx_t idx);
    return buf_en_t'(1) << idx;
  endfunction

endpackage

// File: rtl/line_pix_counter.sv
// Pixel position within the current line, wrapping at IMG_WIDTH-1 (not a
// power-of-two wrap), with a combinational end-of-line strobe.
module line_pix_counter #(
  parameter int IMG_WIDTH = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] pix_cnt,
  output logic              eol
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_WIDTH - 1);

  // The pixel being accepted this cycle is the last one of the line.
  assign eol = pix_valid && (pix_cnt == LAST_PIX);

  // Advance on every accepted pixel; idle cycles leave the position untouched.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      pix_cnt <= '0;
    end else if (pix_valid) begin
      pix_cnt <= eol ? '0 : pix_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/line_buffer_wr_ctrl.sv
// Write-side controller of the 4-line rotating line buffer: steers each pixel
// into the current buffer, rotates buffers at end of line and publishes the
// buffer select used by the read-side 4:1 selectors.
module line_buffer_wr_ctrl
  import line_buf_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_pix_data,
  input  logic              i_pix_valid,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [3:0]        o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [1:0]        o_rd_sel,
  output logic              o_line_done,
  output logic              o_lines_ready
);

  logic [ADDR_W-1:0] pix_cnt;
  logic              eol;
  buf_idx_t          wr_idx;
  line_cnt_t         line_cnt;
  line_cnt_t         line_cnt_next;
  phase_t            phase_next;

  line_pix_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_pix_counter (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (i_pix_valid),
    .pix_cnt   (pix_cnt),
    .eol       (eol)
  );

  // Completed-line count after this cycle and the operating phase it implies.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    line_cnt_next = line_cnt;
    if (eol && (line_cnt != LINE_CNT_FULL)) begin
      line_cnt_next = line_cnt + 1'b1;
    end
    phase_next = (line_cnt_next == LINE_CNT_FULL) ? PHASE_STREAM : PHASE_FILL;
  end

  // Buffer rotation, line counting and the registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx        <= '0;
      line_cnt      <= '0;
      o_wr_data     <= '0;
      o_wr_en       <= '0;
      o_wr_addr     <= '0;
      o_rd_sel      <= '0;
      o_line_done   <= 1'b0;
      o_lines_ready <= 1'b0;
    end else begin
      // The select trails wr_idx by one edge so it flips together with the
      // first write into the new buffer, never exposing it as a completed line.
      o_rd_sel      <= wr_idx;
      line_cnt      <= line_cnt_next;
      // line_cnt saturates, so once STREAM is reached it is held until reset.
      o_lines_ready <= (phase_next == PHASE_STREAM);
      o_line_done   <= eol;
      if (i_pix_valid) begin
        o_wr_en   <= buf_onehot(wr_idx);
        o_wr_addr <= pix_cnt;
        o_wr_data <= i_pix_data;
        if (eol) begin
          wr_idx <= next_buf_idx(wr_idx);
        end
      end else begin
        // Address and data hold their last value during gaps.
        o_wr_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_wr_ctrl.sv
// Self-checking bench for line_buffer_wr_ctrl with a 4-pixel line.
module tb_line_buffer_wr_ctrl;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_pix_data;
  logic          i_pix_valid;
  logic [DW-1:0] o_wr_data;
  logic [3:0]    o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [1:0]    o_rd_sel;
  logic          o_line_done;
  logic          o_lines_ready;

  always #5 clk = ~clk;

  line_buffer_wr_ctrl #(
    .IMG_WIDTH (W),
    .DATA_W    (DW),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pix_data    (i_pix_data),
    .i_pix_valid   (i_pix_valid),
    .o_wr_data     (o_wr_data),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .o_rd_sel      (o_rd_sel),
    .o_line_done   (o_line_done),
    .o_lines_ready (o_lines_ready)
  );

  typedef struct packed {
    logic [3:0]    en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
    logic          ready;
    logic [1:0]    sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected-state model of the writer.
  int m_pix   = 0;
  int m_buf   = 0;
  int m_lines = 0;

  // Last written values, for the hold checks during gaps.
  logic [AW-1:0] last_addr  = '0;
  logic [DW-1:0] last_data  = '0;
  logic          last_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pix = 0; m_buf = 0; m_lines = 0;
    last_addr = '0; last_data = '0; last_ready = 1'b0;
  endtask

  // Drive one valid pixel and push its expected write.
  task automatic pix(input logic [DW-1:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    i_pix_valid = 1'b1;
    i_pix_data  = d;
    e.en   = 4'(1) << m_buf;
    e.addr = AW'(m_pix);
    e.data = d;
    e.sel  = 2'(m_buf);
    e.done = (m_pix == W - 1);
    if (m_pix == W - 1) begin
      m_pix = 0;
      m_buf = (m_buf + 1) % 4;
      if (m_lines < 3) m_lines++;
    end else begin
      m_pix++;
    end
    e.ready = (m_lines == 3);
    exp_q.push_back(e);
  endtask

  // Idle cycles carry junk data that must not reach the outputs.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      i_pix_valid = 1'b0;
      i_pix_data  = 8'hA5;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},       32'(o_wr_en),       32'h0);
    check({tag, "_wr_addr"},     32'(o_wr_addr),     32'h0);
    check({tag, "_wr_data"},     32'(o_wr_data),     32'h0);
    check({tag, "_rd_sel"},      32'(o_rd_sel),      32'h0);
    check({tag, "_line_done"},   32'(o_line_done),   32'h0);
    check({tag, "_lines_ready"}, 32'(o_lines_ready), 32'h0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero(tag);
    model_reset();
    #1 rst = 1'b0;
  endtask

  // Monitor: pops one expectation per presented write, checks holds otherwise.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (o_wr_en != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(o_wr_en), 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_en",       32'(o_wr_en),       32'(mon_e.en));
          check("wr_addr",     32'(o_wr_addr),     32'(mon_e.addr));
          check("wr_data",     32'(o_wr_data),     32'(mon_e.data));
          check("line_done",   32'(o_line_done),   32'(mon_e.done));
          check("lines_ready", 32'(o_lines_ready), 32'(mon_e.ready));
          check("rd_sel",      32'(o_rd_sel),      32'(mon_e.sel));
          check("addr_range",  32'(o_wr_addr < AW'(W)), 32'h1);
          last_addr  = o_wr_addr;
          last_data  = o_wr_data;
          last_ready = o_lines_ready;
        end
      end else begin
        check("idle_line_done",   32'(o_line_done),   32'h0);
        check("hold_addr",        32'(o_wr_addr),     32'(last_addr));
        check("hold_data",        32'(o_wr_data),     32'(last_data));
        check("hold_lines_ready", 32'(o_lines_ready), 32'(last_ready));
      end
    end
  end

  int wait_cnt;

  initial begin
    rst         = 1'b1;
    i_pix_valid = 1'b0;
    i_pix_data  = '0;
    #2 check_all_zero("reset");
    #1 rst = 1'b0;

    // Reset / idle for 10 cycles.
    idle(10);
    check_all_zero("idle10");

    // Single line, back-to-back.
    pix(8'h10); pix(8'h11); pix(8'h12); pix(8'h13);
    idle(2);
    check("line1_rd_sel",    32'(o_rd_sel),    32'h1);
    check("line1_done_low",  32'(o_line_done), 32'h0);

    // Rotation and wrap: 20 continuous pixels from a clean start.
    mid_reset("rst_a");
    for (int i = 0; i < 20; i++) pix(DW'(8'h20 + i));
    idle(2);
    check("stream_rd_sel",      32'(o_rd_sel),      32'h1);
    check("stream_lines_ready", 32'(o_lines_ready), 32'h1);

    // Partial line with ready set, then reset drops ready.
    pix(8'h60); pix(8'h61);
    idle(1);
    mid_reset("rst_ready");

    // Gapped input 1,0,0,1,1,0,1.
    pix(8'h40); idle(2); pix(8'h41); pix(8'h42); idle(1); pix(8'h43);
    idle(2);

    // Reset mid-line after 2 lines plus 2 pixels.
    mid_reset("rst_b");
    for (int i = 0; i < 10; i++) pix(DW'(8'h80 + i));
    idle(1);
    mid_reset("rst_mid");
    pix(8'h77);
    idle(2);
    check("after_rst_rd_sel", 32'(o_rd_sel), 32'h0);

    // Boundary data at addresses 0 and W-1.
    mid_reset("rst_c");
    pix(8'h00); pix(8'h55); pix(8'hAA); pix(8'hFF);
    idle(2);

    // Bounded drain of the scoreboard.
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
